// File: rtl/rename_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rename_pkg                                              |
// | Shared rename-stage constants and physical/arch tag types.       |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package rename_pkg;
   localparam int NUM_PREG = 128;
   localparam int NUM_AREG = 64;
   localparam int DEPTH    = NUM_PREG - NUM_AREG;
   localparam int PREG_W   = 7;
   localparam int PTR_W    = 6;
   localparam int CNT_W    = 7;

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [5:0]        areg_t;
endpackage
`default_nettype wire

// File: rtl/phys_free_list.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : phys_free_list                                          |
// | Circular FIFO of free physical tags: one pop per cycle, up to    |
// | three compacted pushes (rollback 0/1, commit). Optional checker  |
// | enabled by FREELIST_CHECK_EN adds the sticky err output.         |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module phys_free_list
   import rename_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_req,
   output logic              alloc_ready,
   output logic [PREG_W-1:0] alloc_preg,
   input  logic              commit_wb_en,
   input  logic [PREG_W-1:0] commit_P_rd_old,
   input  logic              rollback_en_0,
   input  logic [PREG_W-1:0] rollback_P_rd_new_0,
   input  logic              rollback_en_1,
   input  logic [PREG_W-1:0] rollback_P_rd_new_1,
`ifdef FREELIST_CHECK_EN
   output logic              err,
`endif
   output logic [CNT_W-1:0]  free_count
);

   preg_t            r_entry [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic [2:0]       w_push_v;
   preg_t            w_push_tag [3];
   logic [PTR_W-1:0] w_wr_idx [3];
   logic [1:0]       w_npush;
   logic             w_pop;

   // Number of valid push slots strictly below slot index 'upto'.
   function automatic logic [1:0] prefix_cnt(input logic [2:0] v, input int upto);
      logic [1:0] n;
      n = 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (k < upto && v[k]) n = n + 2'd1;
      end
      return n;
   endfunction

   always_comb begin
      w_push_tag[0] = rollback_P_rd_new_0;
      w_push_tag[1] = rollback_P_rd_new_1;
      w_push_tag[2] = commit_P_rd_old;
      w_push_v[0]   = rollback_en_0 && (rollback_P_rd_new_0 != '0);
      w_push_v[1]   = rollback_en_1 && (rollback_P_rd_new_1 != '0);
      w_push_v[2]   = commit_wb_en  && (commit_P_rd_old     != '0);
      w_npush       = prefix_cnt(w_push_v, 3);
      for (int s = 0; s < 3; s++) begin
         w_wr_idx[s] = r_tail + PTR_W'(prefix_cnt(w_push_v, s));
      end
      w_pop         = alloc_req && (r_count != '0);
   end

   assign alloc_ready = (r_count != '0);
   assign alloc_preg  = r_entry[r_head];
   assign free_count  = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= preg_t'(NUM_AREG + i);
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= CNT_W'(DEPTH);
      end else begin
         // Pushes land on tail slots, which only alias head when empty (no pop then).
         for (int s = 0; s < 3; s++) begin
            if (w_push_v[s]) r_entry[w_wr_idx[s]] <= w_push_tag[s];
         end
         if (w_pop) r_head <= r_head + PTR_W'(1);
         r_tail  <= r_tail + PTR_W'(w_npush);
         r_count <= r_count - CNT_W'(w_pop) + CNT_W'(w_npush);
      end
   end

`ifdef FREELIST_CHECK_EN
   logic [NUM_PREG-1:0] r_is_free;
   logic                r_err;
   logic                w_err_set;

   always_comb begin
      w_err_set = 1'b0;
      for (int s = 0; s < 3; s++) begin
         if (w_push_v[s] && r_is_free[w_push_tag[s]]) w_err_set = 1'b1;
      end
      if (({1'b0, r_count} + (CNT_W+1)'(w_npush)) > (CNT_W+1)'(DEPTH)) w_err_set = 1'b1;
      if (w_pop && !r_is_free[alloc_preg]) w_err_set = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PREG; i++) begin
            r_is_free[i] <= (i >= NUM_AREG);
         end
         r_err <= 1'b0;
      end else begin
         if (w_pop) r_is_free[alloc_preg] <= 1'b0;
         for (int s = 0; s < 3; s++) begin
            if (w_push_v[s]) r_is_free[w_push_tag[s]] <= 1'b1;
         end
         r_err <= r_err | w_err_set;
      end
   end

   assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phys_free_list.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_phys_free_list                                       |
// | Queue-model bench for phys_free_list (FREELIST_CHECK_EN aware).  |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_phys_free_list;
   import rename_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alloc_req = 1'b0;
   logic        alloc_ready;
   logic [6:0]  alloc_preg;
   logic        commit_wb_en = 1'b0;
   logic [6:0]  commit_P_rd_old = '0;
   logic        rollback_en_0 = 1'b0;
   logic [6:0]  rollback_P_rd_new_0 = '0;
   logic        rollback_en_1 = 1'b0;
   logic [6:0]  rollback_P_rd_new_1 = '0;
   logic [6:0]  free_count;
`ifdef FREELIST_CHECK_EN
   logic        err;
`endif

   int checks = 0;
   int errors = 0;
   int q[$];
   int grants[$];
   bit model_on = 1'b0;

   phys_free_list dut (
      .clk                 (clk),
      .rst                 (rst),
      .alloc_req           (alloc_req),
      .alloc_ready         (alloc_ready),
      .alloc_preg          (alloc_preg),
      .commit_wb_en        (commit_wb_en),
      .commit_P_rd_old     (commit_P_rd_old),
      .rollback_en_0       (rollback_en_0),
      .rollback_P_rd_new_0 (rollback_P_rd_new_0),
      .rollback_en_1       (rollback_en_1),
      .rollback_P_rd_new_1 (rollback_P_rd_new_1),
`ifdef FREELIST_CHECK_EN
      .err                 (err),
`endif
      .free_count          (free_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Free list as an ordered queue: pop oldest, append valid nonzero frees in slot order.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         for (int i = 0; i < 64; i++) q.push_back(64 + i);
         model_on = 1'b1;
      end else if (model_on) begin
         if (alloc_req && q.size() != 0) void'(q.pop_front());
         if (rollback_en_0 && rollback_P_rd_new_0 != 0) q.push_back(int'(rollback_P_rd_new_0));
         if (rollback_en_1 && rollback_P_rd_new_1 != 0) q.push_back(int'(rollback_P_rd_new_1));
         if (commit_wb_en && commit_P_rd_old != 0) q.push_back(int'(commit_P_rd_old));
      end
   end

   always @(negedge clk) begin
      if (model_on && !rst) begin
         check("model_ready", int'(alloc_ready), int'(q.size() != 0));
         check("model_count", int'(free_count), q.size());
         if (q.size() != 0) check("model_preg", int'(alloc_preg), q[0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_req     = 1'b0;
      commit_wb_en  = 1'b0;
      rollback_en_0 = 1'b0;
      rollback_en_1 = 1'b0;
      commit_P_rd_old     = '0;
      rollback_P_rd_new_0 = '0;
      rollback_P_rd_new_1 = '0;
   endtask

   task automatic collect_allocs(input int n);
      grants.delete();
      idle();
      alloc_req = 1'b1;
      for (int k = 0; k < n; k++) begin
         if (alloc_ready) grants.push_back(int'(alloc_preg));
         tick();
      end
      alloc_req = 1'b0;
   endtask

   initial begin
      int exp12[12];
      int dups;
      bit seen[128];

      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset_ready", int'(alloc_ready), 1);
      check("reset_preg", int'(alloc_preg), 64);
      check("reset_count", int'(free_count), 64);

      // Drain all 64 tags
      collect_allocs(64);
      check("drain_grants", grants.size(), 64);
      for (int k = 0; k < 64; k++) check("drain_order", grants[k], 64 + k);
      check("drain_ready", int'(alloc_ready), 0);
      check("drain_count", int'(free_count), 0);

      // Free tag 5 while empty, with a same-cycle request that must not grant
      commit_wb_en = 1'b1; commit_P_rd_old = 7'd5; alloc_req = 1'b1;
      tick();
      idle();
      check("refill_ready", int'(alloc_ready), 1);
      check("refill_preg", int'(alloc_preg), 5);
      check("refill_count", int'(free_count), 1);

      // Build count to 10, then rollback x2 + commit + alloc in one cycle
      for (int t = 10; t <= 18; t++) begin
         commit_wb_en = 1'b1; commit_P_rd_old = 7'(t);
         tick();
      end
      idle();
      check("ten_count", int'(free_count), 10);
      alloc_req = 1'b1;
      rollback_en_0 = 1'b1; rollback_P_rd_new_0 = 7'd90;
      rollback_en_1 = 1'b1; rollback_P_rd_new_1 = 7'd91;
      commit_wb_en  = 1'b1; commit_P_rd_old     = 7'd7;
      tick();
      idle();
      check("mixed_count", int'(free_count), 12);
      exp12 = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 90, 91, 7};
      collect_allocs(12);
      check("mixed_grants", grants.size(), 12);
      for (int k = 0; k < 12 && k < grants.size(); k++) check("mixed_order", grants[k], exp12[k]);

      // Tag 0 is never pushed
      commit_wb_en = 1'b1; commit_P_rd_old = 7'd0;
      rollback_en_0 = 1'b1; rollback_P_rd_new_0 = 7'd0;
      tick();
      idle();
      check("x0_count", int'(free_count), 0);
      check("x0_ready", int'(alloc_ready), 0);
      rollback_en_0 = 1'b1; rollback_P_rd_new_0 = 7'd0;
      rollback_en_1 = 1'b1; rollback_P_rd_new_1 = 7'd33;
      commit_wb_en  = 1'b1; commit_P_rd_old     = 7'd0;
      tick();
      idle();
      check("x0_mix_count", int'(free_count), 1);
      check("x0_mix_preg", int'(alloc_preg), 33);

      // Reset while pushes and a pop are in flight
      rst = 1'b1; alloc_req = 1'b1; commit_wb_en = 1'b1; commit_P_rd_old = 7'd12;
      tick();
      rst = 1'b0;
      idle();
      check("midrst_count", int'(free_count), 64);
      check("midrst_preg", int'(alloc_preg), 64);

`ifdef FREELIST_CHECK_EN
      check("err_reset", int'(err), 0);
      alloc_req = 1'b1;
      tick();
      idle();
      commit_wb_en = 1'b1; commit_P_rd_old = 7'd70;
      tick();
      idle();
      check("err_set", int'(err), 1);
      tick();
      tick();
      check("err_sticky", int'(err), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("err_cleared", int'(err), 0);
`endif

      // Wrap: 60 allocs, free 64..123, then 70 allocs
      collect_allocs(60);
      for (int t = 64; t <= 123; t++) begin
         commit_wb_en = 1'b1; commit_P_rd_old = 7'(t);
         tick();
      end
      idle();
      check("wrap_count", int'(free_count), 64);
      collect_allocs(70);
      check("wrap_grants", grants.size(), 64);
      dups = 0;
      foreach (seen[i]) seen[i] = 1'b0;
      for (int k = 0; k < grants.size(); k++) begin
         check("wrap_order", grants[k], (k < 4) ? 124 + k : 60 + k);
         if (seen[grants[k]]) dups++;
         seen[grants[k]] = 1'b1;
      end
      check("wrap_dups", dups, 0);
      check("wrap_ready", int'(alloc_ready), 0);

      // Mixed traffic, pushes gated to stay below capacity
      for (int c = 0; c < 300; c++) begin
         alloc_req = 1'($urandom_range(0, 1));
         if (q.size() <= 60) begin
            rollback_en_0 = 1'($urandom_range(0, 1));
            rollback_P_rd_new_0 = 7'($urandom_range(0, 127));
            rollback_en_1 = 1'($urandom_range(0, 1));
            rollback_P_rd_new_1 = 7'($urandom_range(0, 127));
            commit_wb_en = 1'($urandom_range(0, 1));
            commit_P_rd_old = 7'($urandom_range(0, 127));
         end else begin
            rollback_en_0 = 1'b0;
            rollback_en_1 = 1'b0;
            commit_wb_en  = 1'b0;
         end
         tick();
      end
      idle();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Circular FIFO of free physical register tags, sitting beside rename/dispatch and directly downstream of the reorder buffer's commit and rollback outputs.
- Supplies one new physical destination tag per dispatch cycle.
- Reclaims the old tag when an instruction commits.
- Reclaims up to two new tags per cycle during misprediction rollback.

Parameters:
- NUM_PREG, 128, total physical registers; tag width 7 bits.
- NUM_AREG, 64, architectural registers (integer plus FP), identity-mapped to tags 0..63 at reset.
- DEPTH, NUM_PREG-NUM_AREG (64), FIFO capacity.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- alloc_req  input  1  rename needs a destination tag this cycle
- alloc_ready  output  1  at least one free tag available
- alloc_preg  output  7  tag granted; valid when alloc_ready
- commit_wb_en  input  1  committing instruction wrote a register
- commit_P_rd_old  input  7  previous mapping to release
- rollback_en_0  input  1  rollback slot 0 valid
- rollback_P_rd_new_0  input  7  squashed tag, slot 0
- rollback_en_1  input  1  rollback slot 1 valid
- rollback_P_rd_new_1  input  7  squashed tag, slot 1
- free_count  output  7  number of free tags, 0..DEPTH

Behaviour:
- Storage: DEPTH-entry array of 7-bit tags, 6-bit head and tail pointers with natural wrap, 7-bit count register.
- Reset:
  - entry[i] = NUM_AREG+i; head = 0; tail = 0; count = DEPTH.
  - Outputs after reset: alloc_ready = 1, alloc_preg = 64, free_count = 64.
- Pop:
  - alloc_ready = (count != 0), from registered count only; no bypass of same-cycle pushes.
  - alloc_preg = entry[head], combinational, zero latency.
  - On alloc_req && alloc_ready, head advances by 1 at the clock edge.
  - alloc_req while !alloc_ready is ignored; no state change.
- Push sources, in fixed order:
  - Rollback slot 0: pushes when rollback_en_0 && rollback_P_rd_new_0 != 0.
  - Rollback slot 1: pushes when rollback_en_1 && rollback_P_rd_new_1 != 0.
  - Commit: pushes when commit_wb_en && commit_P_rd_old != 0.
  - Valid pushes are compacted and written to tail, tail+1, tail+2 in that order, each index mod DEPTH.
  - Tail advances by the number of valid pushes, 0..3.
- Tag 0 (x0) is never pushed and never allocated.
- Count update: count_next = count - pop + npush. Width is 7 bits and the value never exceeds DEPTH in legal operation.
- Simultaneous pop and push:
  - Both take effect in the same edge.
  - Pop reads the old head entry; pushes write tail slots, which never alias head unless count == 0.
  - When count == 0 there is no pop, so no hazard exists.
- Full (count == DEPTH) plus a push is illegal: the upstream invariant is that tags are conserved. The RTL performs no clipping. See the optional feature.
- Rollback and alloc in the same cycle: both honoured. Rename is stalled by the ROB during recovery, so this does not arise in the system, but the block must not break if it does.
- Reset mid-operation: everything returns to the reset image in one cycle; in-flight pushes are discarded.

Optional Feature:
- Macro: FREELIST_CHECK_EN.
- When defined:
  - Adds a NUM_PREG-bit is_free vector; reset sets bits 64..127 and clears bits 0..63.
  - Adds an output port err (1 bit, sticky, reset 0).
  - err is set by any of: a push of a tag whose bit is already set (double free); a push while count+npush > DEPTH; an alloc of a tag whose bit is clear.
  - Bits are set on push and cleared on pop.
- When undefined: no vector, no err port, zero area overhead.

Decomposition:
- Shared package (rename_pkg) holds NUM_PREG, NUM_AREG, a preg_t typedef (logic [6:0]) and an areg_t typedef (logic [5:0]).
- No sub-module is natural. The 3-input push compaction is a small inline function (prefix count of valid bits), and the block remains a single module.

Test Plan:
- Reset, then alloc_req for 64 consecutive cycles -> alloc_preg sequence 64,65,...,127; alloc_ready drops to 0 in the cycle after the 64th grant; free_count = 0.
- From empty, commit_wb_en with P_rd_old = 5 -> next cycle alloc_ready = 1, alloc_preg = 5, free_count = 1. Same-cycle alloc_req while empty -> no grant.
- From count = 10, one cycle with rollback_en_0 (tag 90), rollback_en_1 (tag 91), commit (tag 7) and alloc_req all asserted -> count = 12; subsequent pops after the existing 10 entries return 90, 91, 7 in that order.
- Pushes carrying tag 0 (commit_P_rd_old = 0, rollback_P_rd_new_0 = 0) -> count unchanged, no entry written.
- Wrap: 60 allocs, then 60 commit frees of tags 64..123, then 70 allocs -> pointers wrap past 63. Grant order is 124..127 followed by 64..123, and no duplicate tag is granted.
- With FREELIST_CHECK_EN defined: commit frees tag 70 while 70 is still free -> err = 1 next cycle and stays 1 until rst.
